// File: rtl/mont_pkg.sv
// Shared constants and types for the Montgomery-domain encoder.
`default_nettype none
package mont_pkg;

  localparam int DEFAULT_WIDTH = 512;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mont_enc_state_t;

  // Counter must reach 2*WIDTH-1; one spare bit keeps the compare unambiguous.
  function automatic int cnt_width(input int width);
    return $clog2(2 * width) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mont_encode_if.sv
// Request/response handshake bundle between a requester and mont_encode.
`default_nettype none
interface mont_encode_if #(
  parameter int WIDTH = mont_pkg::DEFAULT_WIDTH
);
  import mont_pkg::*;

  logic             valid_in;
  logic             ready_out;
  logic [WIDTH-1:0] x_in;
  logic [WIDTH-1:0] N_in;
  logic             valid_out;
  logic             ready_in;
  logic [WIDTH-1:0] x_mont_out;
  logic             err_out;

  modport slave (
    input  valid_in, x_in, N_in, ready_in,
    output ready_out, valid_out, x_mont_out, err_out
  );

  modport master (
    output valid_in, x_in, N_in, ready_in,
    input  ready_out, valid_out, x_mont_out, err_out
  );

endinterface
`default_nettype wire

// File: rtl/mont_enc_step.sv
// One restoring-reduction step: r_next = (2r+b >= n) ? 2r+b-n : 2r+b.
`default_nettype none
module mont_enc_step
  import mont_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] i_r,
  input  logic             i_b,
  input  logic [WIDTH-1:0] i_n,
  output logic [WIDTH-1:0] o_r_next
);

  logic [WIDTH:0]   w_t;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;

  assign w_t  = {i_r, i_b};
  assign w_ge = (w_t >= {1'b0, i_n});
  // With r < n the true difference is below 2^WIDTH, so the low bits suffice.
  assign w_diff   = w_t[WIDTH-1:0] - i_n;
  assign o_r_next = w_ge ? w_diff : w_t[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/mont_encode.sv
// Bit-serial conversion x -> (x * 2^WIDTH) mod N. Optional macro
// MONT_ENCODE_CHECK_EN flags even moduli and skips the reduction.
`default_nettype none
module mont_encode
  import mont_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  mont_encode_if.slave  bus
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(2 * WIDTH - 1);

  mont_enc_state_t  r_state;
  mont_enc_state_t  w_state_next;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_s;
  logic [WIDTH-1:0] r_n;
  logic [WIDTH-1:0] r_res;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] w_r_next;
  logic             w_accept;
  logic             w_last;
  logic             w_bad_mod;

  assign w_accept = bus.valid_in && (r_state == IDLE);
  assign w_last   = (r_cnt == C_LAST);

`ifdef MONT_ENCODE_CHECK_EN
  logic r_err;
  assign w_bad_mod   = ~bus.N_in[0];
  assign bus.err_out = r_err;
`else
  assign w_bad_mod   = 1'b0;
  assign bus.err_out = 1'b0;
`endif

  mont_enc_step #(.WIDTH(WIDTH)) u_step (
    .i_r      (r_r),
    .i_b      (r_s[WIDTH-1]),
    .i_n      (r_n),
    .o_r_next (w_r_next)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= IDLE;
    else           r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_next = w_bad_mod ? DONE : RUN;
      RUN:  if (w_last)   w_state_next = DONE;
      DONE: if (bus.ready_in) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_r   <= '0;
      r_s   <= '0;
      r_n   <= '0;
      r_res <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_r   <= '0;
      r_s   <= bus.x_in;
      r_n   <= bus.N_in;
      r_res <= '0;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      // The stream is {x, WIDTH zeros}: zeros shifted in supply the low half.
      r_s   <= {r_s[WIDTH-2:0], 1'b0};
      r_r   <= w_r_next;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) r_res <= w_r_next;
    end
  end

`ifdef MONT_ENCODE_CHECK_EN
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)     r_err <= 1'b0;
    else if (w_accept) r_err <= w_bad_mod;
  end
`endif

  assign bus.ready_out  = (r_state == IDLE);
  assign bus.valid_out  = (r_state == DONE);
  assign bus.x_mont_out = r_res;

endmodule
`default_nettype wire

// File: doc/mont_encode.md
Name: mont_encode

Overview:
- Converts natural-form operands into Montgomery form: x_mont = (x * R) mod N, with R = 2^WIDTH.
- Counterpart of mont_reduction, which removes the R factor. mont_encode sits in front of the multiplier datapath and feeds operands into the Montgomery domain.
- Bit-serial restoring reduction of the 2*WIDTH-bit value x*2^WIDTH. No multiplier and no N_prime needed.

Parameters:
- WIDTH, 512, operand and modulus width in bits; R = 2^WIDTH.

Ports:
- clk_in  input  1  clock, rising edge
- rst_n_in  input  1  asynchronous active-low reset
- valid_in  input  1  request valid
- ready_out  output  1  block can accept a request (IDLE)
- x_in  input  WIDTH  natural operand; any value, including x_in >= N_in
- N_in  input  WIDTH  modulus; odd and nonzero for valid results
- valid_out  output  1  result valid; held until accepted
- ready_in  input  1  downstream accepts result
- x_mont_out  output  WIDTH  (x_in * 2^WIDTH) mod N_in
- err_out  output  1  qualified by valid_out; invalid modulus (see Optional Feature)

Behaviour:
- Reset:
  - Asynchronous, active-low.
  - State=IDLE, ready_out=1, valid_out=0, x_mont_out=0, err_out=0.
  - Internal remainder r, shift register and counter are cleared.
  - Reset mid-RUN or mid-DONE aborts the operation with no output.
- States: IDLE, RUN, DONE.
- IDLE:
  - ready_out=1.
  - On valid_in && ready_out: latch x_in into shift register s and N_in into n_q; set r=0, cnt=0; go to RUN.
  - Inputs are sampled only on the accept edge.
- RUN:
  - ready_out=0. One bit per cycle, MSB first, over the 2*WIDTH-bit stream {x, WIDTH zeros}.
  - Each cycle: t = 2*r + b, where b = MSB of s. Shift s left, filling with 0.
  - r_next = (t >= n_q) ? t - n_q : t.
  - t needs WIDTH+1 bits. The compare/subtract is done at WIDTH+1 bits. Invariant: r < n_q.
  - cnt increments each cycle. After the cycle in which cnt == 2*WIDTH-1: x_mont_out=r_next[WIDTH-1:0], valid_out=1, go to DONE.
- Latency: valid_out rises exactly 2*WIDTH clock edges after the accepting edge. For WIDTH=512 this is 1024 cycles.
- DONE:
  - valid_out=1; x_mont_out and err_out stable.
  - On ready_in: valid_out=0, go to IDLE. ready_out returns to 1 on the next cycle, so no same-cycle back-to-back accept.
- Boundary conditions:
  - ready_in asserted while not DONE: ignored.
  - valid_in while busy: ignored; the upstream holds it.
  - x_in=0: result 0.
  - x_in >= N_in: reduced correctly; no precondition on x_in.
- Throughput: one conversion per 2*WIDTH+2 cycles.

Optional Feature:
- Macro: MONT_ENCODE_CHECK_EN.
- Defined:
  - On accept, if N_in[0]==0 (which includes N_in==0), skip RUN and go directly to DONE on the next edge.
  - In that case err_out=1 and x_mont_out=0.
  - Valid moduli: err_out=0.
- Undefined:
  - err_out is tied to 0.
  - Every request runs the full 2*WIDTH cycles. The result is still (x*R) mod N for any nonzero N; N==0 gives an unspecified result.

Decomposition:
- Package mont_pkg holds:
  - default WIDTH constant;
  - typedef enum logic [1:0] {IDLE, RUN, DONE} mont_enc_state_t;
  - counter width function, $clog2(2*WIDTH)+1.
- Sub-module mont_enc_step (combinational): inputs r, b, n; output r_next. This is the double-add-conditional-subtract step, and it can be unit-tested alone.

Test Plan:
- WIDTH=16, N=33227, x=46 -> x_mont_out=24226, err_out=0. valid_out rises exactly 32 edges after accept.
- WIDTH=16, N=33227:
  - x=89 -> 17979.
  - x=4094 -> 29586.
  - Feeding 24226*17979 through mont_reduction yields 29586 (round-trip consistency).
- WIDTH=16, N=33227, x=65535 (x >= N) -> 12967. x=0 -> 0.
- Handshake: hold ready_in=0 for 10 cycles after valid_out -> x_mont_out is stable and valid_out stays 1. valid_in pulsed during RUN -> ignored. ready_out returns 1 the cycle after ready_in.
- With MONT_ENCODE_CHECK_EN: N=33226, x=5 -> valid_out 1 edge after accept, err_out=1, x_mont_out=0. Without the macro, the same N -> 32 cycles, err_out=0.
- Reset: assert rst_n_in low at cycle 10 of RUN -> outputs go to reset values immediately (asynchronous). After release, a new request N=33227, x=46 -> 24226.
